// File: rtl/screen_mem_arb_pkg.sv
// Shared types and default geometry for the screen RAM arbiter.
// Address layout: {row, word-in-line}, one bit per pixel.
package screen_pkg;

    localparam int SCR_ADDR_W = 13;
    localparam int SCR_DATA_W = 16;
    localparam int SCR_LINE_W = 5;
    localparam int SCR_ROW_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } arb_state_t;

    // Owner of the read data returning from the RAM one cycle after issue.
    typedef enum logic [1:0] {
        NONE,
        CPU,
        LB
    } ret_tag_t;

endpackage

// File: rtl/screen_mem_arb_if.sv
// Bus bundle between the arbiter (slave) and the CPU / RAM / pixel side (master).
// All signals are cycle-level; grants and RAM strobes are combinational on the slave side.
interface screen_mem_arb_if
    import screen_pkg::*;
#(
    parameter int ADDR_W = SCR_ADDR_W,
    parameter int DATA_W = SCR_DATA_W,
    parameter int LINE_W = SCR_LINE_W,
    parameter int ROW_W  = SCR_ROW_W
);
    logic              line_req;
    logic [ROW_W-1:0]  line_num;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              lb_we;
    logic [LINE_W-1:0] lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    logic              fetch_busy;
    logic              fetch_done;
    logic              fetch_overrun;
    logic [15:0]       stall_cnt;

    modport slave (
        input  line_req, line_num, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata,
        output lb_we, lb_waddr, lb_wdata, fetch_busy, fetch_done, fetch_overrun, stall_cnt
    );

    modport master (
        output line_req, line_num, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata,
        input  lb_we, lb_waddr, lb_wdata, fetch_busy, fetch_done, fetch_overrun, stall_cnt
    );

endinterface

// File: rtl/screen_arb_wait_cnt.sv
// Counts consecutive refused cycles of a pending CPU request, saturating at MAX_WAIT;
// o_force demands the next slot for the CPU once the bound is reached.
module screen_arb_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cpu_req,
    input  logic i_cpu_gnt,
    output logic o_force
);
    localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_cpu_req || i_cpu_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force = i_cpu_req && (r_cnt == CNT_MAX);

endmodule

// File: rtl/screen_mem_arb.sv
// Screen RAM arbiter: CPU vs. line prefetch, CPU granted same cycle, read data 1 cycle later;
// CPU waits at most CPU_MAX_WAIT cycles during a fetch. Optional stall counter: SCREEN_ARB_STATS_EN.
module screen_mem_arb
    import screen_pkg::*;
#(
    parameter int ADDR_W       = SCR_ADDR_W,
    parameter int DATA_W       = SCR_DATA_W,
    parameter int LINE_W       = SCR_LINE_W,
    parameter int ROW_W        = SCR_ROW_W,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    screen_mem_arb_if.slave bus
);
    arb_state_t        r_state;
    logic [ROW_W-1:0]  r_line;
    logic [LINE_W-1:0] r_word;
    ret_tag_t          r_tag;
    logic [LINE_W-1:0] r_lb_idx;
    logic              r_fetch_done;

    logic w_force;
    logic w_cpu_gnt;
    logic w_fetch_slot;
    logic w_lb_we;
    logic w_cpu_rvalid;

    screen_arb_wait_cnt #(
        .MAX_WAIT (CPU_MAX_WAIT)
    ) u_wait_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_cpu_req (bus.cpu_req),
        .i_cpu_gnt (w_cpu_gnt),
        .o_force   (w_force)
    );

    // Slot selection: the fetch owns FETCH cycles unless the CPU wait bound has been hit.
    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_fetch_slot = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:    w_cpu_gnt = bus.cpu_req;
                FETCH: begin
                    w_cpu_gnt    = w_force;
                    w_fetch_slot = !w_force;
                end
                DRAIN:   w_cpu_gnt = bus.cpu_req;
                default: w_cpu_gnt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_line       <= '0;
            r_word       <= '0;
            r_tag        <= NONE;
            r_lb_idx     <= '0;
            r_fetch_done <= 1'b0;
        end else begin
            r_fetch_done <= 1'b0;
            if (w_fetch_slot) begin
                r_tag    <= LB;
                r_lb_idx <= r_word;
            end else if (w_cpu_gnt && !bus.cpu_we) begin
                r_tag <= CPU;
            end else begin
                r_tag <= NONE;
            end
            case (r_state)
                IDLE: begin
                    if (bus.line_req) begin
                        r_line  <= bus.line_num;
                        r_word  <= '0;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (w_fetch_slot) begin
                        r_word <= r_word + 1'b1;
                        if (&r_word) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_state      <= IDLE;
                    r_fetch_done <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.mem_en    = w_cpu_gnt | w_fetch_slot;
    assign bus.mem_we    = w_cpu_gnt & bus.cpu_we;
    assign bus.mem_addr  = w_fetch_slot ? {r_line, r_word} : (w_cpu_gnt ? bus.cpu_addr : '0);
    assign bus.mem_wdata = w_cpu_gnt ? bus.cpu_wdata : '0;

    // Returns in flight while rst is high are dropped.
    assign w_lb_we        = !rst && (r_tag == LB);
    assign w_cpu_rvalid   = !rst && (r_tag == CPU);
    assign bus.lb_we      = w_lb_we;
    assign bus.lb_waddr   = w_lb_we ? r_lb_idx : '0;
    assign bus.lb_wdata   = w_lb_we ? bus.mem_rdata : '0;
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : '0;

    assign bus.fetch_busy    = (r_state != IDLE);
    assign bus.fetch_done    = r_fetch_done;
    assign bus.fetch_overrun = !rst && bus.line_req && (r_state != IDLE);

`ifdef SCREEN_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (bus.cpu_req && !w_cpu_gnt && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_screen_mem_arb.sv
// Randomized bench for screen_mem_arb with an in-bench rule-level model and directed scenarios.
module tb_screen_mem_arb;
    localparam int WORDS = 32;
    localparam int MAXW  = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 0;

    screen_mem_arb_if bus ();

    screen_mem_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram [0:8191];
    logic [15:0] ram_rd_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model of the rules: fetch progress as "words issued so far", drain when all 32 are out.
    bit          m_busy;
    int          m_issued;
    int          m_line;
    int          m_refused;
    int          m_ret;          // 0 nothing, 1 CPU read, 2 line-buffer word
    logic [15:0] m_ret_data;
    int          m_ret_idx;
    bit          m_done;
    int          m_stall;
    bit          e_gnt, e_fetch, e_drain, e_lb, e_rv;
    int          e_addr;

    always @(negedge clk) begin
        if (started) begin
            e_drain = m_busy && (m_issued == WORDS);
            if (rst)                   e_gnt = 1'b0;
            else if (!m_busy || e_drain) e_gnt = bus.cpu_req;
            else                       e_gnt = bus.cpu_req && (m_refused >= MAXW);
            e_fetch = !rst && m_busy && !e_drain && !e_gnt;
            e_addr  = e_fetch ? (m_line * WORDS + m_issued) : (e_gnt ? int'(bus.cpu_addr) : 0);
            e_lb    = !rst && (m_ret == 2);
            e_rv    = !rst && (m_ret == 1);

            chk("cpu_gnt",       bus.cpu_gnt, e_gnt);
            chk("mem_en",        bus.mem_en, e_gnt | e_fetch);
            chk("mem_we",        bus.mem_we, e_gnt & bus.cpu_we);
            chk("mem_addr",      bus.mem_addr, e_addr);
            chk("mem_wdata",     bus.mem_wdata, e_gnt ? bus.cpu_wdata : 16'h0);
            chk("lb_we",         bus.lb_we, e_lb);
            chk("lb_waddr",      bus.lb_waddr, e_lb ? m_ret_idx : 0);
            chk("lb_wdata",      bus.lb_wdata, e_lb ? m_ret_data : 16'h0);
            chk("cpu_rvalid",    bus.cpu_rvalid, e_rv);
            chk("cpu_rdata",     bus.cpu_rdata, e_rv ? m_ret_data : 16'h0);
            chk("fetch_busy",    bus.fetch_busy, m_busy);
            chk("fetch_done",    bus.fetch_done, m_done);
            chk("fetch_overrun", bus.fetch_overrun, !rst && bus.line_req && m_busy);
`ifdef SCREEN_ARB_STATS_EN
            chk("stall_cnt",     bus.stall_cnt, m_stall);
`else
            chk("stall_cnt",     bus.stall_cnt, 0);
`endif

            if (rst) begin
                m_busy = 0; m_issued = 0; m_refused = 0; m_ret = 0; m_done = 0; m_stall = 0;
            end else begin
                if (bus.cpu_req && !e_gnt && m_stall < 65535) m_stall++;
                m_ret      = e_fetch ? 2 : ((e_gnt && !bus.cpu_we) ? 1 : 0);
                m_ret_data = ram[e_addr];
                m_ret_idx  = m_issued;
                m_refused  = (bus.cpu_req && !e_gnt) ? ((m_refused + 1 > MAXW) ? MAXW : m_refused + 1) : 0;
                m_done     = e_drain;
                if (!m_busy) begin
                    if (bus.line_req) begin
                        m_busy = 1; m_issued = 0; m_line = int'(bus.line_num);
                    end
                end else if (e_drain) begin
                    m_busy = 0;
                end else if (e_fetch) begin
                    m_issued++;
                end
            end
        end
        // RAM macro behaviour, driven by what the DUT actually presents.
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] = bus.mem_wdata;
                ram_rd_next = 16'($urandom);
            end else begin
                ram_rd_next = ram[bus.mem_addr];
            end
        end else begin
            ram_rd_next = 16'($urandom);
        end
    end

    task automatic drive(input bit r, input bit lreq, input logic [7:0] lnum, input bit creq,
                         input bit cwe, input logic [12:0] caddr, input logic [15:0] cwd,
                         output bit gnt);
        @(posedge clk);
        #1;
        rst           = r;
        bus.line_req  = lreq;
        bus.line_num  = lnum;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.mem_rdata = ram_rd_next;
        @(negedge clk);
        gnt = bus.cpu_gnt;
    endtask

    task automatic idle(input int n);
        bit g;
        for (int i = 0; i < n; i++) drive(0, 0, 8'd0, 0, 0, 13'd0, 16'd0, g);
    endtask

    bit          g;
    int          first_addr, lb_cnt, last_idx, done_cyc, gnt_cnt, rv_cnt, run, max_run;
    bit          a_req, a_we;
    logic [12:0] a_addr;
    logic [15:0] a_wd;

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 16'($urandom);
        ram_rd_next   = 16'h0;
        rst           = 1'b1;
        bus.line_req  = 0; bus.line_num = 0; bus.cpu_req = 0; bus.cpu_we = 0;
        bus.cpu_addr  = 0; bus.cpu_wdata = 0; bus.mem_rdata = 0;
        drive(1, 0, 8'd0, 0, 0, 13'd0, 16'd0, g);
        drive(1, 0, 8'd0, 0, 0, 13'd0, 16'd0, g);
        started = 1;
        drive(1, 0, 8'd0, 0, 0, 13'd0, 16'd0, g);
        idle(1);
        chk("reset_busy",  bus.fetch_busy, 0);
        chk("reset_stall", bus.stall_cnt, 0);
        chk("reset_lb_we", bus.lb_we, 0);

        // CPU write then read-back in IDLE.
        drive(0, 0, 8'd0, 1, 1, 13'h0005, 16'hA5A5, g);
        chk("s1_gnt", g, 1);
        chk("s1_mem_en", bus.mem_en, 1);
        chk("s1_mem_we", bus.mem_we, 1);
        chk("s1_mem_addr", bus.mem_addr, 5);
        drive(0, 0, 8'd0, 1, 0, 13'h0005, 16'h0, g);
        idle(1);
        chk("s1_rvalid", bus.cpu_rvalid, 1);
        chk("s1_rdata", bus.cpu_rdata, 16'hA5A5);
        idle(2);

        // Uncontended fetch of line 3.
        drive(0, 1, 8'd3, 0, 0, 13'd0, 16'd0, g);
        first_addr = -1; lb_cnt = 0; last_idx = -1; done_cyc = -1;
        for (int c = 1; c < 80 && done_cyc < 0; c++) begin
            idle(1);
            if (bus.mem_en && first_addr < 0) first_addr = int'(bus.mem_addr);
            if (bus.lb_we) begin lb_cnt++; last_idx = int'(bus.lb_waddr); end
            if (bus.fetch_done) done_cyc = c;
        end
        chk("s2_first_addr", first_addr, 96);
        chk("s2_lb_count", lb_cnt, 32);
        chk("s2_last_idx", last_idx, 31);
        chk("s2_done_cycle", done_cyc, 34);
        idle(2);

        // Fetch with the CPU reading continuously.
        a_addr = 13'($urandom);
        drive(0, 1, 8'd3, 1, 0, a_addr, 16'd0, g);
        gnt_cnt = g; rv_cnt = 0; run = 0; max_run = 0; done_cyc = -1;
        if (g) a_addr = 13'($urandom);
        for (int c = 1; c < 80 && done_cyc < 0; c++) begin
            drive(0, 0, 8'd0, 1, 0, a_addr, 16'd0, g);
            if (g) begin gnt_cnt++; run = 0; a_addr = 13'($urandom); end
            else begin run++; if (run > max_run) max_run = run; end
            if (bus.cpu_rvalid) rv_cnt++;
            if (bus.fetch_done) done_cyc = c;
        end
        chk("s3_done_cycle", done_cyc, 41);
        chk("s3_max_refused", max_run, 4);
        chk("s3_grants", gnt_cnt, 10);
        chk("s3_rvalids", rv_cnt, 9);
`ifdef SCREEN_ARB_STATS_EN
        chk("s3_stall_cnt", bus.stall_cnt, 32);
`else
        chk("s3_stall_cnt", bus.stall_cnt, 0);
`endif
        idle(3);

        // Overrun: second request ten cycles in.
        drive(0, 1, 8'd3, 0, 0, 13'd0, 16'd0, g);
        done_cyc = -1; first_addr = 0;
        for (int c = 1; c < 80 && done_cyc < 0; c++) begin
            if (c == 10) begin
                drive(0, 1, 8'd7, 0, 0, 13'd0, 16'd0, g);
                chk("s4_overrun", bus.fetch_overrun, 1);
            end else begin
                idle(1);
            end
            if (bus.mem_en && (bus.mem_addr < 96 || bus.mem_addr > 127)) first_addr++;
            if (bus.fetch_done) done_cyc = c;
        end
        chk("s4_bad_addrs", first_addr, 0);
        chk("s4_done_cycle", done_cyc, 34);
        idle(2);

        // Reset while word 15 would be issued, then a fresh fetch.
        drive(0, 1, 8'd3, 0, 0, 13'd0, 16'd0, g);
        idle(15);
        drive(1, 0, 8'd0, 0, 0, 13'd0, 16'd0, g);
        idle(1);
        chk("s5_lb_we", bus.lb_we, 0);
        chk("s5_busy", bus.fetch_busy, 0);
        chk("s5_mem_en", bus.mem_en, 0);
        drive(0, 1, 8'd9, 0, 0, 13'd0, 16'd0, g);
        idle(1);
        chk("s5_restart_addr", bus.mem_addr, 288);
        idle(40);

        // Random traffic; the compare process carries the checking.
        a_req = 0; a_we = 0; a_wd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!a_req && $urandom_range(0, 1) == 0) begin
                a_req = 1; a_we = 1'($urandom_range(0, 1));
                a_addr = 13'($urandom); a_wd = 16'($urandom);
            end
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0), 8'($urandom),
                  a_req, a_we, a_addr, a_wd, g);
            if (g) a_req = 0;
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/screen_mem_arb.md
Name: screen_mem_arb

Overview:
- Arbitrates the single-port screen RAM between two requesters:
  - the CPU (Hack-style 16-bit memory-mapped writes and reads);
  - a display line-prefetch engine, which fills a one-line buffer consumed by the pixel generator.
- Sequences each line prefetch when the display timing requests it.
- Guarantees CPU forward progress through a bounded-wait rule.
- Sits between the CPU bus, the screen RAM macro and the pixel pipeline.

Parameters:
- ADDR_W, 13, screen RAM word-address width.
- DATA_W, 16, RAM word width; 1 bit per pixel.
- LINE_W, 5, log2 of words per display line; 32 words = 512 pixels.
- ROW_W, 8, line-number width; 256 lines. Requires ROW_W + LINE_W == ADDR_W.
- CPU_MAX_WAIT, 4, maximum consecutive cycles a pending CPU request may be refused during a fetch.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset. Synchronous, active-high.
- line_req, in, 1: one-cycle pulse requesting prefetch of line line_num.
- line_num, in, ROW_W: line to fetch; sampled when line_req=1.
- cpu_req, in, 1: CPU access request; held until granted.
- cpu_we, in, 1: 1 = write, 0 = read.
- cpu_addr, in, ADDR_W: CPU word address.
- cpu_wdata, in, DATA_W: CPU write data.
- cpu_gnt, out, 1: request accepted this cycle.
- cpu_rvalid, out, 1: read data valid; 1 cycle after a read grant.
- cpu_rdata, out, DATA_W: read data.
- mem_en, out, 1: RAM access strobe.
- mem_we, out, 1: RAM write enable.
- mem_addr, out, ADDR_W: RAM address.
- mem_wdata, out, DATA_W: RAM write data.
- mem_rdata, in, DATA_W: RAM read data; 1-cycle latency.
- lb_we, out, 1: line-buffer write strobe.
- lb_waddr, out, LINE_W: line-buffer word index.
- lb_wdata, out, DATA_W: line-buffer write data.
- fetch_busy, out, 1: a line fetch is in progress.
- fetch_done, out, 1: one-cycle pulse after the last word is written to the line buffer.
- fetch_overrun, out, 1: one-cycle pulse when line_req arrives while fetch_busy=1.
- stall_cnt, out, 16: CPU stall statistics (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; word index 0; wait counter 0.
- FSM state IDLE:
  - line_req=1 → latch line_num, word index := 0, go to FETCH.
  - Otherwise a CPU request is granted in the same cycle: cpu_gnt=1, mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - If line_req and cpu_req coincide, the CPU is granted that cycle and FETCH issues its first read on the next cycle.
- FSM state FETCH, per-cycle slot selection:
  - The CPU slot is taken if cpu_req=1 and wait counter == CPU_MAX_WAIT. The CPU is granted and the wait counter clears.
  - Otherwise the fetch slot is taken: mem_en=1, mem_we=0, mem_addr={line_reg, word_idx}, then word_idx += 1.
  - Wait counter: increments while cpu_req=1 and refused; clears on grant or when cpu_req=0; saturates at CPU_MAX_WAIT.
  - After the read for word_idx = 2^LINE_W − 1 is issued, go to DRAIN.
- FSM state DRAIN: one cycle for the last read return; the CPU may be granted. Then go to IDLE and pulse fetch_done.
- Read returns:
  - For a fetch read issued in cycle N, in cycle N+1: lb_we=1, lb_waddr = registered index, lb_wdata=mem_rdata.
  - For a CPU read granted in cycle N, in cycle N+1: cpu_rvalid=1, cpu_rdata=mem_rdata.
  - Data-return tags are registered; no mixing is possible because only one access is issued per cycle.
- fetch_busy=1 in FETCH and DRAIN.
- line_req while fetch_busy=1: request ignored, fetch_overrun pulses, the current fetch continues unchanged.
- Worst-case fetch length: 32 + ceil(32 / CPU_MAX_WAIT) + 1 cycles.
- A CPU write to the line being fetched has no coherency guarantee; the display sees old or new data.
- rst asserted mid-fetch: the FSM returns to IDLE next edge; pending returns are discarded, with no lb_we and no cpu_rvalid.

Optional Feature:
- Macro: SCREEN_ARB_STATS_EN.
- Defined: stall_cnt counts cycles with cpu_req=1 and cpu_gnt=0. It saturates at 16'hFFFF and clears on rst.
- Undefined: stall_cnt is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package screen_pkg holds:
  - the FSM enum arb_state_t {IDLE, FETCH, DRAIN};
  - the SCR_ADDR_W, SCR_DATA_W, SCR_LINE_W, SCR_ROW_W constants;
  - the return-tag typedef {NONE, CPU, LB}.
- One sub-module, screen_arb_wait_cnt: the saturating CPU wait counter plus grant-force logic.

Test Plan:
- Reset, then CPU write addr 13'h0005 data 16'hA5A5 in IDLE → cpu_gnt same cycle; mem_en=1, mem_we=1, mem_addr=5.
- line_req with line_num=3, no CPU traffic → 32 reads at mem_addr 96..127 on consecutive cycles. lb_we on cycles +1..+32 with lb_waddr 0..31, then fetch_done.
- line_req with line 3 while cpu_req is held high as reads → CPU granted after exactly 4 refused cycles, repeating. Fetch completes in 41 cycles; cpu_rvalid returns correct data.
- Second line_req 10 cycles into a fetch → fetch_overrun pulse; fetch continues on line 3 and ends normally.
- rst asserted at word 15 of a fetch → next cycle all outputs 0, no lb_we; a new line_req fetches from word 0.
- With SCREEN_ARB_STATS_EN: the scenario-3 pattern yields stall_cnt=32 after the fetch. Without the macro, stall_cnt=0.
